// File: rtl/spi_sclk_gen_pkg.sv
// spi_sclk_gen_pkg: shared SPI definitions (state encoding, default widths, mode constants)
package spi_sclk_gen_pkg;
    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 6;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;
    // {CPOL,CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_half_period_cnt.sv
// spi_half_period_cnt: half-period counter 0..div, tick on the wrap cycle
// Ports: clk, rst (sync, active-high), clr (restart at 0), en (count enable),
//        div (terminal count), tick (high while enabled and count == div)
module spi_half_period_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] div,
    output logic         tick
);
    logic [W-1:0] hcnt;
    assign tick = en && (hcnt == div);
    always_ff @(posedge clk) begin
        if (rst || clr) hcnt <= '0;
        else if (en) hcnt <= tick ? '0 : hcnt + 1'b1;
    end
endmodule

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI serial-clock burst generator with CPOL/CPHA and sample/shift strobes
// Ports: CLK_I, RST (sync, active-high); START/ABORT requests; DIV (half-period-1),
//        LEN (SCLK cycles), CPOL, CPHA latched on START; SCLK_O, SAMPLE_STB, SHIFT_STB,
//        BUSY, DONE, EDGE_IDX are all registered outputs.
module spi_sclk_gen
    import spi_sclk_gen_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK_I,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [DIV_W-1:0] DIV,
    input  logic [CNT_W-1:0] LEN,
    input  logic             CPOL,
    input  logic             CPHA,
    output logic             SCLK_O,
    output logic             SAMPLE_STB,
    output logic             SHIFT_STB,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] EDGE_IDX
);
    state_t           state;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] len_q;
    logic             cpol_q, cpha_q, phase;
    logic [CNT_W:0]   ecnt;
    logic [CNT_W:0]   n_edges;
    logic             all_done, tick, lead, trail_vis, start_ok;

    assign n_edges   = {len_q, 1'b0};
    assign all_done  = ecnt == n_edges;
    // the edge about to be registered is odd (leading) when the count so far is even
    assign lead      = ~ecnt[0];
    // a non-final trailing edge is on the outputs this cycle
    assign trail_vis = (SAMPLE_STB || SHIFT_STB) && !ecnt[0] && !all_done;
    assign start_ok  = (state == ST_IDLE) && START && !ABORT;

    spi_half_period_cnt #(.W(DIV_W)) u_hcnt (
        .clk (CLK_I),
        .rst (RST),
        .clr (start_ok),
        .en  ((state == ST_RUN) && !all_done),
        .div (div_q),
        .tick(tick)
    );

    always_ff @(posedge CLK_I) begin
        if (RST) begin
            state      <= ST_IDLE;
            div_q      <= '0;
            len_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            phase      <= 1'b0;
            ecnt       <= '0;
            SCLK_O     <= 1'b0;
            SAMPLE_STB <= 1'b0;
            SHIFT_STB  <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            EDGE_IDX   <= '0;
        end else begin
            SAMPLE_STB <= 1'b0;
            SHIFT_STB  <= 1'b0;
            DONE       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    SCLK_O <= CPOL;
                    BUSY   <= 1'b0;
                    if (start_ok) begin
                        div_q    <= DIV;
                        len_q    <= LEN;
                        cpol_q   <= CPOL;
                        cpha_q   <= CPHA;
                        phase    <= 1'b0;
                        ecnt     <= '0;
                        EDGE_IDX <= '0;
                        state    <= (LEN == '0) ? ST_FIN : ST_RUN;
                        BUSY     <= LEN != '0;
                        DONE     <= LEN == '0;
                    end
                end
                ST_RUN: begin
                    if (ABORT) begin
                        state  <= ST_IDLE;
                        SCLK_O <= cpol_q;
                        BUSY   <= 1'b0;
                    end else if (all_done) begin
                        state  <= ST_FIN;
                        SCLK_O <= cpol_q;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                    end else begin
                        if (tick) begin
                            ecnt       <= ecnt + 1'b1;
                            phase      <= ~phase;
                            SCLK_O     <= cpol_q ^ ~phase;
                            SAMPLE_STB <= lead ^ cpha_q;
                            SHIFT_STB  <= cpha_q ? lead : (!lead && (ecnt + 1'b1) != n_edges);
                        end
                        if (trail_vis && EDGE_IDX != len_q - 1'b1) EDGE_IDX <= EDGE_IDX + 1'b1;
                    end
                end
                ST_FIN: begin
                    state  <= ST_IDLE;
                    SCLK_O <= cpol_q;
                    BUSY   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: directed self-checking bench for spi_sclk_gen
module tb_spi_sclk_gen;
    import spi_sclk_gen_pkg::*;

    logic       clk = 1'b0;
    logic       RST = 1'b1, START = 1'b0, ABORT = 1'b0, CPOL = 1'b0, CPHA = 1'b0;
    logic [7:0] DIV = '0;
    logic [5:0] LEN = '0;
    logic       SCLK_O, SAMPLE_STB, SHIFT_STB, BUSY, DONE;
    logic [5:0] EDGE_IDX;

    int checks = 0;
    int fails  = 0;
    logic [31:0] m_sclk, m_samp, m_shift, m_busy, m_done;

    always #5 clk = ~clk;

    spi_sclk_gen dut (
        .CLK_I(clk), .RST(RST), .START(START), .ABORT(ABORT), .DIV(DIV), .LEN(LEN),
        .CPOL(CPOL), .CPHA(CPHA), .SCLK_O(SCLK_O), .SAMPLE_STB(SAMPLE_STB),
        .SHIFT_STB(SHIFT_STB), .BUSY(BUSY), .DONE(DONE), .EDGE_IDX(EDGE_IDX)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masks();
        m_sclk = '0; m_samp = '0; m_shift = '0; m_busy = '0; m_done = '0;
    endtask

    task automatic sample(input int c);
        m_sclk[c]  = SCLK_O;
        m_samp[c]  = SAMPLE_STB;
        m_shift[c] = SHIFT_STB;
        m_busy[c]  = BUSY;
        m_done[c]  = DONE;
    endtask

    task automatic test_reset();
        RST = 1'b1; CPOL = 1'b1; START = 1'b1;
        step(); step();
        checks++;
        if ({SCLK_O, SAMPLE_STB, SHIFT_STB, BUSY, DONE, EDGE_IDX} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs got %b want 0", {SCLK_O, SAMPLE_STB, SHIFT_STB, BUSY, DONE, EDGE_IDX});
        end
        START = 1'b0; RST = 1'b0; CPOL = 1'b0;
        step(); step();
        checks++;
        if (SCLK_O !== 1'b0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got sclk=%b busy=%b want 0 0", SCLK_O, BUSY);
        end
    endtask

    task automatic test_mode0_div0();
        logic [5:0] idx3, idx16;
        idx3 = 'x; idx16 = 'x;
        clear_masks();
        DIV = 8'd0; LEN = 6'd8; {CPOL, CPHA} = MODE0;
        step(); step();
        for (int c = 0; c < 24; c++) begin
            sample(c);
            if (c == 3) idx3 = EDGE_IDX;
            if (c == 16) idx16 = EDGE_IDX;
            START = (c == 0);
            step();
        end
        START = 1'b0;
        checks++; if (m_samp !== 32'h0001_5554) begin fails++; $display("FAIL m0_sample got %h want %h", m_samp, 32'h0001_5554); end
        checks++; if (m_shift !== 32'h0000_AAA8) begin fails++; $display("FAIL m0_shift got %h want %h", m_shift, 32'h0000_AAA8); end
        checks++; if (m_busy !== 32'h0003_FFFE) begin fails++; $display("FAIL m0_busy got %h want %h", m_busy, 32'h0003_FFFE); end
        checks++; if (m_done !== 32'h0004_0000) begin fails++; $display("FAIL m0_done got %h want %h", m_done, 32'h0004_0000); end
        checks++; if (m_sclk !== 32'h0001_5554) begin fails++; $display("FAIL m0_sclk got %h want %h", m_sclk, 32'h0001_5554); end
        checks++; if (idx3 !== 6'd0 || idx16 !== 6'd7) begin fails++; $display("FAIL m0_edge_idx got %0d,%0d want 0,7", idx3, idx16); end
    endtask

    task automatic test_mode3_div3();
        clear_masks();
        DIV = 8'd3; LEN = 6'd2; {CPOL, CPHA} = MODE3;
        step(); step();
        for (int c = 0; c < 24; c++) begin
            sample(c);
            START = (c == 0);
            step();
        end
        START = 1'b0;
        checks++; if (m_sclk !== 32'h00FE_1E1F) begin fails++; $display("FAIL m3_sclk got %h want %h", m_sclk, 32'h00FE_1E1F); end
        checks++; if (m_shift !== 32'h0000_2020) begin fails++; $display("FAIL m3_shift got %h want %h", m_shift, 32'h0000_2020); end
        checks++; if (m_samp !== 32'h0002_0200) begin fails++; $display("FAIL m3_sample got %h want %h", m_samp, 32'h0002_0200); end
        checks++; if (m_done !== 32'h0004_0000) begin fails++; $display("FAIL m3_done got %h want %h", m_done, 32'h0004_0000); end
        checks++; if (m_busy !== 32'h0003_FFFE) begin fails++; $display("FAIL m3_busy got %h want %h", m_busy, 32'h0003_FFFE); end
    endtask

    task automatic test_len_zero();
        clear_masks();
        DIV = 8'd5; LEN = 6'd0; {CPOL, CPHA} = MODE2;
        step(); step();
        for (int c = 0; c < 8; c++) begin
            sample(c);
            START = (c == 0);
            step();
        end
        START = 1'b0;
        checks++; if (m_done !== 32'h0000_0002) begin fails++; $display("FAIL len0_done got %h want %h", m_done, 32'h2); end
        checks++; if (m_busy !== 32'h0) begin fails++; $display("FAIL len0_busy got %h want 0", m_busy); end
        checks++; if ((m_samp | m_shift) !== 32'h0) begin fails++; $display("FAIL len0_strobes got %h want 0", m_samp | m_shift); end
        checks++; if (m_sclk !== 32'h0000_00FF) begin fails++; $display("FAIL len0_sclk got %h want %h", m_sclk, 32'hFF); end
    endtask

    task automatic test_abort();
        clear_masks();
        DIV = 8'd1; LEN = 6'd4; {CPOL, CPHA} = MODE0;
        step(); step();
        for (int c = 0; c < 20; c++) begin
            sample(c);
            START = (c == 0) || (c == 10);
            ABORT = (c == 8);
            if (c == 10) begin DIV = 8'd0; LEN = 6'd1; {CPOL, CPHA} = MODE1; end
            step();
        end
        START = 1'b0;
        checks++; if (m_sclk !== 32'h0000_1198) begin fails++; $display("FAIL abort_sclk got %h want %h", m_sclk, 32'h1198); end
        checks++; if (m_samp !== 32'h0000_2088) begin fails++; $display("FAIL abort_sample got %h want %h", m_samp, 32'h2088); end
        checks++; if (m_shift !== 32'h0000_1020) begin fails++; $display("FAIL abort_shift got %h want %h", m_shift, 32'h1020); end
        checks++; if (m_busy !== 32'h0000_39FE) begin fails++; $display("FAIL abort_busy got %h want %h", m_busy, 32'h39FE); end
        checks++; if (m_done !== 32'h0000_4000) begin fails++; $display("FAIL abort_done got %h want %h", m_done, 32'h4000); end
    endtask

    task automatic test_ignore_live();
        clear_masks();
        DIV = 8'd1; LEN = 6'd3; {CPOL, CPHA} = MODE0;
        step(); step();
        for (int c = 0; c < 20; c++) begin
            sample(c);
            START = (c == 0) || (c == 5) || (c == 14);
            if (c == 2) begin DIV = 8'd5; LEN = 6'd9; end
            step();
        end
        START = 1'b0;
        checks++; if (m_sclk !== 32'h0000_1998) begin fails++; $display("FAIL live_sclk got %h want %h", m_sclk, 32'h1998); end
        checks++; if (m_samp !== 32'h0000_0888) begin fails++; $display("FAIL live_sample got %h want %h", m_samp, 32'h888); end
        checks++; if (m_shift !== 32'h0000_0220) begin fails++; $display("FAIL live_shift got %h want %h", m_shift, 32'h220); end
        checks++; if (m_busy !== 32'h0000_3FFE) begin fails++; $display("FAIL live_busy got %h want %h", m_busy, 32'h3FFE); end
        checks++; if (m_done !== 32'h0000_4000) begin fails++; $display("FAIL live_done got %h want %h", m_done, 32'h4000); end
    endtask

    task automatic test_rst_mid();
        logic [10:0] v7;
        logic [5:0]  idx6;
        v7 = 'x; idx6 = 'x;
        clear_masks();
        DIV = 8'd1; LEN = 6'd4; {CPOL, CPHA} = MODE2;
        step(); step();
        for (int c = 0; c < 10; c++) begin
            sample(c);
            if (c == 6) idx6 = EDGE_IDX;
            if (c == 7) v7 = {SCLK_O, SAMPLE_STB, SHIFT_STB, BUSY, DONE, EDGE_IDX};
            START = (c == 0);
            RST = (c == 6);
            step();
        end
        START = 1'b0; RST = 1'b0;
        checks++; if (idx6 !== 6'd1) begin fails++; $display("FAIL rst_idx_before got %0d want 1", idx6); end
        checks++; if (v7 !== 11'd0) begin fails++; $display("FAIL rst_mid_outputs got %b want 0", v7); end
        checks++; if (m_sclk !== 32'h0000_0367) begin fails++; $display("FAIL rst_sclk got %h want %h", m_sclk, 32'h367); end
        checks++; if (m_busy !== 32'h0000_007E) begin fails++; $display("FAIL rst_busy got %h want %h", m_busy, 32'h7E); end
        checks++; if (m_samp !== 32'h8 || m_shift !== 32'h20 || m_done !== 32'h0) begin
            fails++;
            $display("FAIL rst_strobes got %h/%h/%h want 8/20/0", m_samp, m_shift, m_done);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_div0();
        test_mode3_div3();
        test_len_zero();
        test_abort();
        test_ignore_live();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
- Parametrised SPI serial-clock generator; next generation of the single-factor divider in the SPI interface.
- Produces a gated burst of exactly LEN SCLK cycles at a programmable rate, with CPOL/CPHA mode selection.
- Emits single-cycle SAMPLE/SHIFT strobes for the SPI shift register and a DONE handshake to the SPI controller FSM.
- Sits between the SPI controller FSM and the pad-side SCLK driver.

Parameters:
- DIV_W, 8: width of the DIV input; half-period is DIV+1 CLK_I cycles.
- CNT_W, 6: width of LEN and EDGE_IDX; maximum burst is 2^CNT_W-1 SCLK cycles.

Ports:
- CLK_I  in  1  system clock; the only clock in the block.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  one-cycle request; accepted only in IDLE.
- ABORT  in  1  terminate the burst; synchronous.
- DIV  in  DIV_W  half-period minus 1, latched on START.
- LEN  in  CNT_W  number of SCLK cycles in the burst, latched on START.
- CPOL  in  1  idle clock level; live in IDLE, latched on START.
- CPHA  in  1  clock phase, latched on START.
- SCLK_O  out  1  registered serial clock.
- SAMPLE_STB  out  1  one-cycle pulse coincident with each sample edge.
- SHIFT_STB  out  1  one-cycle pulse coincident with each shift edge.
- BUSY  out  1  high while the burst runs.
- DONE  out  1  one-cycle pulse when the burst completes.
- EDGE_IDX  out  CNT_W  current bit index, 0..LEN-1.

Behaviour:
- Reset: RST high is synchronous and overrides everything, including mid-burst.
  - State goes to IDLE.
  - SCLK_O, SAMPLE_STB, SHIFT_STB, BUSY, DONE and EDGE_IDX are all 0.
  - Shadow registers are cleared.
- States: IDLE, RUN, FIN.
- IDLE:
  - SCLK_O is registered from the live CPOL each cycle.
  - START accepted at cycle 0: latch DIV_q, LEN_q, CPOL_q, CPHA_q; clear hcnt, edge counter and EDGE_IDX.
  - If LEN==0, go to FIN. Otherwise go to RUN.
  - START is ignored in RUN and FIN.
- RUN:
  - BUSY=1 from cycle 1. hcnt counts 0..DIV_q.
  - When hcnt==DIV_q, hcnt wraps and edge k is registered (k=1..2*LEN_q). Edge k is visible at cycle 1+k*(DIV_q+1).
  - SCLK_O = CPOL_q XOR phase. phase toggles on each edge and is 0 at START.
  - Odd k is a leading edge; even k is a trailing edge.
- Strobe rules (strobes and SCLK_O change in the same cycle; both registered):
  - CPHA_q=0: SAMPLE_STB on every leading edge; SHIFT_STB on every trailing edge except k=2*LEN_q.
  - CPHA_q=1: SHIFT_STB on every leading edge; SAMPLE_STB on every trailing edge.
- EDGE_IDX increments in the cycle after each trailing edge, except the last. It saturates at LEN_q-1.
- Edge counter is CNT_W+1 bits wide, so 2*LEN_q cannot overflow.
- After edge 2*LEN_q, go to FIN.
- FIN (one cycle): DONE=1, BUSY=0, SCLK_O=CPOL_q, then return to IDLE. A START in the FIN cycle is ignored.
- ABORT:
  - In RUN, the next cycle is IDLE: SCLK_O=CPOL_q for that cycle, strobes 0, BUSY 0, no DONE.
  - In IDLE, ABORT suppresses a same-cycle START.
- Live input changes: changes on DIV/LEN/CPOL/CPHA during RUN have no effect until the next START.
- Simultaneous RST with ABORT or START: RST wins.

Decomposition:
- Shared SPI package holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_FIN;
  - the default DIV_W and CNT_W;
  - mode constants MODE0..MODE3 = {CPOL,CPHA}.
- One natural sub-module: spi_half_period_cnt (hcnt with load/clear, outputs the wrap tick). The FSM and edge logic live in the top.

Test Plan:
- DIV=0, LEN=8, mode 0, START at cycle 0:
  - edges at cycles 2..17;
  - SAMPLE_STB at 2,4,…,16 (8 pulses);
  - SHIFT_STB at 3,5,…,15 (7 pulses);
  - BUSY over cycles 1–17; DONE at 18; SCLK_O=0 afterwards.
- DIV=3, LEN=2, mode 3:
  - SCLK_O idles at 1; falls at 5, rises 9, falls 13, rises 17;
  - SHIFT_STB at 5,13; SAMPLE_STB at 9,17;
  - DONE at 18.
- LEN=0, START: DONE at cycle 1, BUSY never high, no strobes, SCLK_O steady at CPOL.
- DIV=1, LEN=4, mode 0, ABORT at cycle 8:
  - cycle 9 is IDLE with SCLK_O=0;
  - no DONE;
  - a new START at 10 is accepted with fresh shadow values.
- START pulsed at cycle 5 of a running burst, and DIV changed mid-burst: both ignored; edge timing unchanged; DONE at the expected cycle.
- RST at cycle 6 of a mode-2 burst: cycle 7 has all outputs 0 including SCLK_O. After RST release with CPOL=1, SCLK_O=1 one cycle later.
